pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central stall/flush controller for the 5-stage RV32I pipeline.
- Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the PC enable.
- Resolves load-use hazards and EX-stage taken branches/jumps.
- Sequences multi-cycle data-memory accesses with a wait/timeout FSM that freezes the whole pipeline until the memory responds.

Parameters:
- MEM_TIMEOUT, 16, maximum wait cycles for mem_ready before error (legal range 1..255).
- CNT_W, 8, width of the internal wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- id_rs1  in  5  rs1 of instruction in ID
- id_rs2  in  5  rs2 of instruction in ID
- ex_rd  in  5  rd of instruction in EX
- ex_is_load  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- mem_req  in  1  MEM stage holds a valid load/store
- mem_ready  in  1  data memory completes the access this cycle
- en_pc  out  1  PC register enable
- en_ifid  out  1  IF/ID enable
- en_idex  out  1  ID/EX enable
- en_exmem  out  1  EX/MEM enable
- en_memwb  out  1  MEM/WB enable
- flush_ifid  out  1  IF/ID clear (synchronous, applied with enable)
- flush_idex  out  1  ID/EX clear
- mem_hold  out  1  request held pending; memory must keep the access stable
- mem_err  out  1  sticky timeout error
- stall_cycles  out  32  perf counter (see Optional Feature)
- flush_count  out  32  perf counter (see Optional Feature)

Behaviour:
- FSM states RUN, WAIT, ERR. Registered state plus wait counter cnt[CNT_W-1:0]. All control outputs are combinational from state and inputs.
- Reset (synchronous, active-high) behaviour:
  - Next edge: state=RUN, cnt=0, mem_err=0, counters=0.
  - While reset is high, all enables=0 and flushes=1.
  - Reset mid-WAIT or in ERR returns to RUN and abandons the access.
- Load-use hazard: luh = ex_is_load && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
- Memory stall: memstall = (state==RUN && mem_req && !mem_ready) || state==WAIT&&!mem_ready || state==ERR.
- Priority, highest first:
  1. memstall: all five enables=0, flushes=0, mem_hold=1 (ERR: mem_hold=0).
  2. ex_branch_taken: all enables=1, flush_ifid=1, flush_idex=1.
  3. luh: en_pc=0, en_ifid=0, en_idex=1, flush_idex=1 (bubble), en_exmem=en_memwb=1.
  4. Otherwise: all enables=1, flushes=0.
- Branch and luh in the same cycle: branch wins, because the ID instruction is squashed.
- Branch during memstall is deferred; it is still present in EX when the pipeline releases.
- FSM transitions:
  - RUN:
    - mem_req && !mem_ready -> WAIT, cnt=1.
    - mem_req && mem_ready is single-cycle, stays RUN with zero stall.
  - WAIT:
    - mem_ready -> RUN. The release cycle applies normal priority 2-4 that same cycle, so the access completes with no extra bubble.
    - Else if cnt==MEM_TIMEOUT -> ERR, mem_err=1.
    - Else cnt=cnt+1.
  - ERR: pipeline frozen, mem_err held at 1 until reset; mem_ready ignored.
- Latency: a memory access with N wait cycles stalls the pipeline exactly N cycles. Timeout is flagged after MEM_TIMEOUT cycles of waiting.
- mem_req dropping while in WAIT is illegal; the block keeps waiting (assertion in the bench).
- Counters wrap modulo 2^32.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on each cycle where en_pc==0 and reset is low.
  - flush_count increments on each cycle where flush_ifid or flush_idex is 1 and reset is low. A cycle with both counts once.
- Undefined: both outputs are tied to 0 and no counter flops are inferred. The ports remain present.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5 for one cycle -> en_pc=0, en_ifid=0, flush_idex=1 that cycle. Repeat with ex_rd=0 -> no stall.
- Branch vs hazard: ex_branch_taken=1 with luh true -> flush_ifid=1, flush_idex=1, en_pc=1.
- Multi-cycle memory: mem_req=1, mem_ready low for 3 cycles then high -> all enables=0 and mem_hold=1 for exactly 3 cycles, enables=1 on the 4th cycle, state back to RUN.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_err=1 after cycle 5 and stays 1 with mem_ready=1. Reset high one edge -> mem_err=0, state RUN.
- Reset during WAIT after 2 wait cycles -> next edge RUN, cnt=0, enables follow inputs after reset deasserts.
- With PIPE_PERF_CNT_EN: 3-cycle memory stall plus one load-use plus one branch -> stall_cycles=4, flush_count=2. Without the macro both read 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: load-use bubbles, branch squash, memory wait/timeout.
// Optional perf counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        en_pc,
  output logic        en_ifid,
  output logic        en_idex,
  output logic        en_exmem,
  output logic        en_memwb,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        mem_hold,
  output logic        mem_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             luh;
  logic             memstall;

  assign luh = ex_is_load && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  assign memstall = ((state == S_RUN) && mem_req && !mem_ready)
                 || ((state == S_WAIT) && !mem_ready)
                 || (state == S_ERR);

  // State and wait counter; reset abandons any pending access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: wait for mem_ready, give up after MEM_TIMEOUT counted wait cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_RUN: begin
        if (mem_req && !mem_ready) begin
          state_nxt = S_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(MEM_TIMEOUT)) begin
          state_nxt = S_ERR;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_ERR: begin
        state_nxt = S_ERR;
      end
      default: begin
        state_nxt = S_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Control outputs: memory freeze beats branch squash beats load-use bubble.
  always_comb begin
    en_pc      = 1'b1;
    en_ifid    = 1'b1;
    en_idex    = 1'b1;
    en_exmem   = 1'b1;
    en_memwb   = 1'b1;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    mem_hold   = 1'b0;
    mem_err    = (state == S_ERR);
    if (reset) begin
      en_pc      = 1'b0;
      en_ifid    = 1'b0;
      en_idex    = 1'b0;
      en_exmem   = 1'b0;
      en_memwb   = 1'b0;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (memstall) begin
      en_pc    = 1'b0;
      en_ifid  = 1'b0;
      en_idex  = 1'b0;
      en_exmem = 1'b0;
      en_memwb = 1'b0;
      mem_hold = (state != S_ERR);
    end else if (ex_branch_taken) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (luh) begin
      en_pc      = 1'b0;
      en_ifid    = 1'b0;
      flush_idex = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Perf counters; a cycle flushing both registers counts once.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!en_pc) stall_q <= stall_q + 32'd1;
      if (flush_ifid || flush_idex) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl against a cycle-level behavioural model of the stall/flush rules.
module tb_pipeline_ctrl;

  localparam int unsigned MT = 4;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_is_load, ex_branch_taken, mem_req, mem_ready;
  logic        en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic        flush_ifid, flush_idex, mem_hold, mem_err;
  logic [31:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex),
    .en_exmem(en_exmem), .en_memwb(en_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .mem_hold(mem_hold), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  // Model: wait cycles spent on the current access, sticky error, perf totals.
  int          waits;
  bit          err;
  logic [31:0] m_stall, m_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, predict, compare at negedge, advance the model.
  task automatic step(input bit rst, input bit br, input bit ld,
                      input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                      input bit mreq, input bit mrdy);
    bit         luh, mstall, e_hold;
    logic [4:0] e_en;
    logic [1:0] e_fl;
    reset = rst; ex_branch_taken = br; ex_is_load = ld;
    ex_rd = rd; id_rs1 = r1; id_rs2 = r2; mem_req = mreq; mem_ready = mrdy;
    if (!rst && !err && waits > 0)
      assert (mreq) else $error("stimulus dropped mem_req during a pending access");
    luh    = ld && (rd != 5'd0) && ((rd == r1) || (rd == r2));
    mstall = err || (mreq && !mrdy);
    e_hold = 1'b0;
    if (rst) begin
      e_en = 5'b00000; e_fl = 2'b11;
    end else if (mstall) begin
      e_en = 5'b00000; e_fl = 2'b00; e_hold = !err;
    end else if (br) begin
      e_en = 5'b11111; e_fl = 2'b11;
    end else if (luh) begin
      e_en = 5'b00111; e_fl = 2'b01;
    end else begin
      e_en = 5'b11111; e_fl = 2'b00;
    end
    @(negedge clk);
    check("enables", 32'({en_pc, en_ifid, en_idex, en_exmem, en_memwb}), 32'(e_en));
    check("flushes", 32'({flush_ifid, flush_idex}), 32'(e_fl));
    check("mem_hold", 32'(mem_hold), 32'(e_hold));
    check("mem_err", 32'(mem_err), 32'(err));
    check("stall_cycles", stall_cycles, PERF ? m_stall : 32'd0);
    check("flush_count", flush_count, PERF ? m_flush : 32'd0);
    if (rst) begin
      waits = 0; err = 1'b0; m_stall = '0; m_flush = '0;
    end else begin
      if (!e_en[4]) m_stall = m_stall + 32'd1;
      if (|e_fl)    m_flush = m_flush + 32'd1;
      if (!err) begin
        if (mreq && !mrdy) begin
          if (waits == int'(MT)) err = 1'b1;
          else waits++;
        end else begin
          waits = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; ex_branch_taken = 1'b0; ex_is_load = 1'b0;
    ex_rd = '0; id_rs1 = '0; id_rs2 = '0; mem_req = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    waits = 0; err = 1'b0; m_stall = '0; m_flush = '0;

    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // 3-wait memory access, then one load-use, then one branch
    repeat (3) step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle();
    check("perf_stall_total", stall_cycles, PERF ? 32'd4 : 32'd0);
    check("perf_flush_total", flush_count, PERF ? 32'd2 : 32'd0);

    // x0 destination never stalls; branch wins over load-use
    step(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0);
    // Deferred branch during a memory stall
    step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);

    // Timeout: error is sticky and ignores mem_ready until reset
    repeat (MT + 1) step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    check("err_after_timeout", 32'(mem_err), 32'd1);
    repeat (2) step(1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("err_cleared", 32'(mem_err), 32'd0);
    idle();

    // Reset mid-wait abandons the access
    repeat (2) step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0);
    idle();

    for (int i = 0; i < 3000; i++) begin
      bit rst, mreq;
      rst  = ($urandom_range(0, 99) == 0) || (err && ($urandom_range(0, 3) == 0));
      mreq = (waits > 0 && !err) ? 1'b1 : ($urandom_range(0, 2) == 0);
      step(rst, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           mreq, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
